// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 active-low matrix keypad one column at a time,
// debounces whole-keypad scan results and reports the accepted key as a hex
// code with a one-cycle valid strobe and a held level.
// Optional auto-repeat of key_valid while a key is held: define KEYPAD_REPEAT_EN.
module keypad_scanner #(
  parameter int unsigned SCAN_DIV       = 17,
  parameter int unsigned DEBOUNCE_SCANS = 4,
  parameter int unsigned REPEAT_SCANS   = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key,
  output logic       key_valid,
  output logic       key_held
);

  localparam logic [1:0] IDLE        = 2'd0;
  localparam logic [1:0] DEB_PRESS   = 2'd1;
  localparam logic [1:0] PRESSED     = 2'd2;
  localparam logic [1:0] DEB_RELEASE = 2'd3;

  localparam logic [3:0] DEB     = 4'(DEBOUNCE_SCANS);
  localparam logic       DEB_ONE = (DEBOUNCE_SCANS == 32'd1);

  if (SCAN_DIV < 2) begin : g_bad_scan_div
    $error("keypad_scanner: SCAN_DIV must be at least 2");
  end
  if (DEBOUNCE_SCANS < 1 || DEBOUNCE_SCANS > 15) begin : g_bad_debounce
    $error("keypad_scanner: DEBOUNCE_SCANS must be in 1..15");
  end
  if (REPEAT_SCANS < 1) begin : g_bad_repeat
    $error("keypad_scanner: REPEAT_SCANS must be at least 1");
  end

  logic [3:0]          row_m;
  logic [3:0]          row_s;
  logic [SCAN_DIV-1:0] div;
  logic                tick;
  logic [1:0]          colidx;
  logic                scan_done;

  logic [2:0] col_cnt;
  logic [1:0] col_row;
  logic [3:0] tot;
  logic [1:0] acc_cnt;
  logic [3:0] acc_code;
  logic [1:0] sum_cnt;
  logic [3:0] sum_code;
  logic       res_none;
  logic       res_one;

  logic [1:0] state;
  logic [3:0] dcnt;
  logic [3:0] dnext;
  logic [3:0] cand;

`ifdef KEYPAD_REPEAT_EN
  localparam int unsigned      REP_W   = $clog2(REPEAT_SCANS + 1);
  localparam logic [REP_W-1:0] REP_LIM = REP_W'(REPEAT_SCANS);
  logic [REP_W-1:0] rep;
  logic [REP_W-1:0] rep_next;
  assign rep_next = rep + 1'b1;
`endif

  // Row code for a single low row r in column c.
  function automatic logic [3:0] map_key(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] k;
    k = '0;
    case ({r, c})
      4'h0: k = 4'h1;
      4'h1: k = 4'h2;
      4'h2: k = 4'h3;
      4'h3: k = 4'hA;
      4'h4: k = 4'h4;
      4'h5: k = 4'h5;
      4'h6: k = 4'h6;
      4'h7: k = 4'hB;
      4'h8: k = 4'h7;
      4'h9: k = 4'h8;
      4'hA: k = 4'h9;
      4'hB: k = 4'hC;
      4'hC: k = 4'h0;
      4'hD: k = 4'hF;
      4'hE: k = 4'hE;
      4'hF: k = 4'hD;
      default: k = '0;
    endcase
    return k;
  endfunction

  assign col       = ~(4'b0001 << colidx);
  assign tick      = &div;
  assign scan_done = tick && (colidx == 2'd3);
  assign dnext     = dcnt + 4'd1;

  // Two-flop synchronizer for the asynchronous keypad rows (idle high).
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      row_m <= '1;
      row_s <= '1;
    end else begin
      row_m <= row;
      row_s <= row_m;
    end
  end

  // Free-running scan step divider.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      div <= '0;
    end else begin
      div <= div + 1'b1;
    end
  end

  // Count low rows in the driven column and remember which one.
  always_comb begin
    col_cnt = '0;
    col_row = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (!row_s[i]) begin
        col_cnt = col_cnt + 3'd1;
        col_row = 2'(i);
      end
    end
  end

  // Merge this column into the running scan result; count saturates at 2 (MULTI).
  always_comb begin
    tot      = {2'b00, acc_cnt} + {1'b0, col_cnt};
    sum_cnt  = (tot >= 4'd2) ? 2'd2 : tot[1:0];
    sum_code = (col_cnt == 3'd1) ? map_key(col_row, colidx) : acc_code;
    res_none = (sum_cnt == 2'd0);
    res_one  = (sum_cnt == 2'd1);
  end

  // Step the column on each tick and accumulate the partial scan result.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      colidx   <= '0;
      acc_cnt  <= '0;
      acc_code <= '0;
    end else if (tick) begin
      colidx <= colidx + 2'd1;
      if (colidx == 2'd3) begin
        acc_cnt  <= '0;
        acc_code <= '0;
      end else begin
        acc_cnt  <= sum_cnt;
        acc_code <= sum_code;
      end
    end
  end

  // Press/release debounce FSM, advanced once per completed full scan.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      dcnt      <= '0;
      cand      <= '0;
      key       <= '0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rep       <= '0;
`endif
    end else begin
      key_valid <= 1'b0;
      if (scan_done) begin
        case (state)
          IDLE: begin
            if (res_one) begin
              cand <= sum_code;
              if (DEB_ONE) begin
                state     <= PRESSED;
                key       <= sum_code;
                key_valid <= 1'b1;
                key_held  <= 1'b1;
                dcnt      <= '0;
`ifdef KEYPAD_REPEAT_EN
                rep       <= '0;
`endif
              end else begin
                state <= DEB_PRESS;
                dcnt  <= 4'd1;
              end
            end
          end
          DEB_PRESS: begin
            if (!res_one) begin
              state <= IDLE;
              dcnt  <= '0;
            end else if (sum_code != cand) begin
              cand <= sum_code;
              dcnt <= 4'd1;
            end else if (dnext == DEB) begin
              state     <= PRESSED;
              key       <= cand;
              key_valid <= 1'b1;
              key_held  <= 1'b1;
              dcnt      <= '0;
`ifdef KEYPAD_REPEAT_EN
              rep       <= '0;
`endif
            end else begin
              dcnt <= dnext;
            end
          end
          PRESSED: begin
            if (res_none) begin
              if (DEB_ONE) begin
                state    <= IDLE;
                key_held <= 1'b0;
                dcnt     <= '0;
              end else begin
                state <= DEB_RELEASE;
                dcnt  <= 4'd1;
              end
            end
`ifdef KEYPAD_REPEAT_EN
            else if (rep_next == REP_LIM) begin
              rep       <= '0;
              key_valid <= 1'b1;
            end else begin
              rep <= rep_next;
            end
`endif
          end
          DEB_RELEASE: begin
            if (!res_none) begin
              state <= PRESSED;
              dcnt  <= '0;
            end else if (dnext == DEB) begin
              state    <= IDLE;
              dcnt     <= '0;
              key_held <= 1'b0;
            end else begin
              dcnt <= dnext;
            end
          end
          default: begin
            state <= IDLE;
            dcnt  <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: drives a simulated 4x4 keypad whose pressed-key set changes
// only on full-scan boundaries, and checks the scanner every cycle against a
// scan-level model of the press/release debounce rules.
module tb_keypad_scanner;

  localparam int unsigned SD   = 2;
  localparam int unsigned DEB  = 2;
  localparam int unsigned REP  = 3;
  localparam int unsigned SCAN = 16;

  localparam logic [3:0] KMAP [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                                       4'h4, 4'h5, 4'h6, 4'hB,
                                       4'h7, 4'h8, 4'h9, 4'hC,
                                       4'h0, 4'hF, 4'hE, 4'hD};

  localparam logic [15:0] K1 = 16'h0001;
  localparam logic [15:0] KA = 16'h0008;
  localparam logic [15:0] K6 = 16'h0040;
  localparam logic [15:0] K9 = 16'h0400;
  localparam logic [15:0] KF = 16'h2000;
  localparam logic [15:0] KD = 16'h8000;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [3:0]  key;
  logic        key_valid;
  logic        key_held;
  logic [15:0] mask = '0;

  logic [15:0] scanq [$];
  int          errors = 0;
  int          checks = 0;
  int          pulses = 0;
  int          pc;

  logic        m_held = 1'b0;
  logic [3:0]  m_key  = '0;
  logic [3:0]  m_cand = '0;
  int          m_run  = 0;
  int          m_rep  = 0;
  logic        pv;
  logic [3:0]  exp_col;

  keypad_scanner #(
    .SCAN_DIV      (SD),
    .DEBOUNCE_SCANS(DEB),
    .REPEAT_SCANS  (REP)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .row      (row),
    .col      (col),
    .key      (key),
    .key_valid(key_valid),
    .key_held (key_held)
  );

  always #5 clock = ~clock;

  // Physical keypad: a pressed key pulls its row low while its column is driven low.
  always_comb begin
    row = '1;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (mask[r*4+c] && !col[c]) row[r] = 1'b0;
  end

  // Clocks elapsed since reset release.
  always @(posedge clock or posedge reset) begin
    if (reset) pc <= 0;
    else       pc <= pc + 1;
  end

  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // One full scan's worth of debounce rules applied to the pressed-key set.
  task automatic model_scan(input logic [15:0] m, output logic pulse);
    int n;
    int idx;
    n     = $countones(m);
    idx   = 0;
    pulse = 1'b0;
    for (int i = 0; i < 16; i++) if (m[i]) idx = i;
    if (!m_held) begin
      if (n == 1) begin
        if (m_run > 0 && KMAP[idx] == m_cand) m_run++;
        else begin
          m_cand = KMAP[idx];
          m_run  = 1;
        end
        if (m_run == int'(DEB)) begin
          m_held = 1'b1;
          m_key  = m_cand;
          pulse  = 1'b1;
          m_run  = 0;
          m_rep  = 0;
        end
      end else begin
        m_run = 0;
      end
    end else if (n == 0) begin
      m_run++;
      if (m_run == int'(DEB)) begin
        m_held = 1'b0;
        m_run  = 0;
      end
    end else begin
`ifdef KEYPAD_REPEAT_EN
      if (m_run == 0) begin
        m_rep++;
        if (m_rep == int'(REP)) begin
          m_rep = 0;
          pulse = 1'b1;
        end
      end
`endif
      m_run = 0;
    end
  endtask

  // Every-cycle comparison against the model; the model advances on scan boundaries.
  always @(negedge clock) begin
    if (reset) begin
      m_held = 1'b0;
      m_key  = '0;
      m_cand = '0;
      m_run  = 0;
      m_rep  = 0;
    end else begin
      pv = 1'b0;
      if (pc > 0 && pc % SCAN == 0) begin
        if (scanq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL scan_queue: got empty, expected a scan entry at t=%0t", $time);
        end else begin
          model_scan(scanq.pop_front(), pv);
        end
      end
      exp_col = ~(4'b0001 << ((pc / 4) % 4));
      chk("col", col, exp_col);
      chk("key_valid", {3'b000, key_valid}, {3'b000, pv});
      chk("key", key, m_key);
      chk("key_held", {3'b000, key_held}, {3'b000, m_held});
      if (key_valid) pulses++;
    end
  end

  task automatic run_scan(input logic [15:0] m);
    mask = m;
    scanq.push_back(m);
    repeat (SCAN) @(posedge clock);
    #2;
  endtask

  task automatic hold(input logic [15:0] m, input int n);
    for (int i = 0; i < n; i++) run_scan(m);
  endtask

  initial begin
    int p0;
    int sel;
    logic [15:0] m;

    #3 reset = 1'b1;
    #1;
    chk("rst_col", col, 4'b1110);
    chk("rst_key", key, 4'h0);
    chk("rst_valid", {3'b000, key_valid}, 4'h0);
    chk("rst_held", {3'b000, key_held}, 4'h0);
    @(posedge clock);
    #2 reset = 1'b0;

    hold('0, 2);
    chk("idle_held", {3'b000, key_held}, 4'h0);

    // '6' pressed and released
    p0 = pulses;
    hold(K6, 2);
    chk("k6_key", key, 4'h6);
    chk("k6_valid", {3'b000, key_valid}, 4'h1);
    chk("k6_held", {3'b000, key_held}, 4'h1);
    hold(K6, 2);
    hold('0, 1);
    chk("k6_rel_deb_held", {3'b000, key_held}, 4'h1);
    hold('0, 1);
    chk("k6_rel_held", {3'b000, key_held}, 4'h0);
    chk("k6_rel_key", key, 4'h6);
    hold('0, 1);
    chk("k6_pulses", 4'(pulses - p0), 4'd1);

    // reset in the middle of a scan while a key is held
    hold(K6, 3);
    chk("pre_rst_held", {3'b000, key_held}, 4'h1);
    repeat (6) @(posedge clock);
    #3 reset = 1'b1;
    #1;
    chk("mid_rst_col", col, 4'b1110);
    chk("mid_rst_key", key, 4'h0);
    chk("mid_rst_valid", {3'b000, key_valid}, 4'h0);
    chk("mid_rst_held", {3'b000, key_held}, 4'h0);
    scanq.delete();
    mask = '0;
    @(posedge clock);
    #2 reset = 1'b0;

    // single-scan tap of 'F' is rejected
    p0 = pulses;
    hold(KF, 1);
    hold('0, 3);
    chk("tap_pulses", 4'(pulses - p0), 4'd0);
    chk("tap_key", key, 4'h0);

    // '1' with '9' is ambiguous; releasing '9' accepts '1'
    p0 = pulses;
    hold(K1 | K9, 3);
    chk("multi_pulses", 4'(pulses - p0), 4'd0);
    chk("multi_held", {3'b000, key_held}, 4'h0);
    hold(K1, 2);
    chk("k1_key", key, 4'h1);
    chk("k1_valid", {3'b000, key_valid}, 4'h1);
    hold(K1, 1);
    hold('0, 3);
    chk("k1_pulses", 4'(pulses - p0), 4'd1);

    // 'A' with a one-scan release bounce
    p0 = pulses;
    hold(KA, 3);
    hold('0, 1);
    chk("ka_bounce_held", {3'b000, key_held}, 4'h1);
    hold(KA, 3);
    hold('0, 2);
    chk("ka_key", key, 4'hA);
    chk("ka_held", {3'b000, key_held}, 4'h0);
`ifndef KEYPAD_REPEAT_EN
    chk("ka_pulses", 4'(pulses - p0), 4'd1);
`endif

`ifdef KEYPAD_REPEAT_EN
    // 'D' held 12 scans: accept on scan 2, repeats on scans 5, 8, 11
    p0 = pulses;
    hold(KD, 12);
    hold('0, 2);
    chk("kd_pulses", 4'(pulses - p0), 4'd4);
    chk("kd_key", key, 4'hD);
`endif

    // randomized key activity
    for (int s = 0; s < 50; s++) begin
      sel = int'($urandom_range(0, 9));
      m   = '0;
      if (sel < 5) begin
        m[$urandom_range(0, 15)] = 1'b1;
      end else if (sel >= 8) begin
        m[$urandom_range(0, 15)] = 1'b1;
        m[$urandom_range(0, 15)] = 1'b1;
      end
      hold(m, int'($urandom_range(1, 4)));
    end
    hold('0, 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
